// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Optional feature macro: IMM_GEN_ILLEGAL_EN (adds illegal_o flag).
package imm_gen_pkg;

    localparam int unsigned INSTR_LO = 7;
    localparam int unsigned INSTR_HI = 31;
    localparam int unsigned SRC_W    = 3;

    typedef enum logic [SRC_W-1:0] {
        IMM_I    = 3'd0,
        IMM_U    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_RSVD = 3'd7
    } imm_src_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream instruction / downstream immediate handshake bundle.
// Optional feature macro: IMM_GEN_ILLEGAL_EN (adds illegal_o).
interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
);

    logic                      in_valid;
    logic                      in_ready;
    logic [INSTR_HI:INSTR_LO]  instr_i;
    logic [SRC_W-1:0]          imm_src;
    logic [TAG_W-1:0]          tag_i;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           imm_o;
    logic [TAG_W-1:0]          tag_o;
`ifdef IMM_GEN_ILLEGAL_EN
    logic                      illegal_o;
`endif

    modport master (
        output in_valid, instr_i, imm_src, tag_i, out_ready,
`ifdef IMM_GEN_ILLEGAL_EN
        input  illegal_o,
`endif
        input  in_ready, out_valid, imm_o, tag_o
    );

    modport slave (
        input  in_valid, instr_i, imm_src, tag_i, out_ready,
`ifdef IMM_GEN_ILLEGAL_EN
        output illegal_o,
`endif
        output in_ready, out_valid, imm_o, tag_o
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all decode formats, XLEN-generic.
// Optional feature macro: IMM_GEN_ILLEGAL_EN (adds illegal_o).
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_HI:INSTR_LO] instr_i,
    input  logic [SRC_W-1:0]         imm_src,
    output logic [XLEN-1:0]          imm_o
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic                     illegal_o
`endif
);

    imm_src_t    w_src;
    logic [31:0] w_imm32;
    logic        w_zext;

    assign w_src = imm_src_t'(imm_src);

    // Build the 32-bit immediate and note whether it widens with zeros
    always_comb begin
        w_imm32 = '0;
        w_zext  = 1'b0;
        case (w_src)
            IMM_I:  w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_U:  w_imm32 = {instr_i[31:12], 12'b0};
            IMM_S:  w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:  w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_J:  w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                               instr_i[20], instr_i[30:21], 1'b0};
            IMM_Z: begin
                w_imm32 = {27'b0, instr_i[19:15]};
                w_zext  = 1'b1;
            end
            IMM_SH: begin
                w_zext = 1'b1;
                if (XLEN == 64) w_imm32 = {26'b0, instr_i[25:20]};
                else            w_imm32 = {27'b0, instr_i[24:20]};
            end
            default: w_imm32 = '0;
        endcase
    end

    // Widen to XLEN: sign-extend unless the format is an unsigned field
    always_comb begin
        if (w_zext) imm_o = XLEN'(w_imm32);
        else        imm_o = XLEN'($signed(w_imm32));
    end

`ifdef IMM_GEN_ILLEGAL_EN
    // Reserved select, or a 6-bit shift amount on a 32-bit machine
    assign illegal_o = (w_src == IMM_RSVD) ||
                       ((w_src == IMM_SH) && (XLEN == 32) && instr_i[25]);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a two-entry valid/ready skid buffer.
// Optional feature macro: IMM_GEN_ILLEGAL_EN (adds illegal_o, registered with imm_o).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    imm_gen_pipe_if.slave  bus
);

`ifdef IMM_GEN_ILLEGAL_EN
    localparam int unsigned PAY_W = XLEN + TAG_W + 1;
`else
    localparam int unsigned PAY_W = XLEN + TAG_W;
`endif

    logic [XLEN-1:0]  w_imm;
    logic [PAY_W-1:0] w_in_pay;
    logic             w_acc;
    logic             w_main_ld;

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [PAY_W-1:0] r_main_pay;
    logic [PAY_W-1:0] r_skid_pay;

`ifdef IMM_GEN_ILLEGAL_EN
    logic w_ill;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (bus.instr_i),
        .imm_src   (bus.imm_src),
        .imm_o     (w_imm),
        .illegal_o (w_ill)
    );

    assign w_in_pay      = {w_ill, bus.tag_i, w_imm};
    assign bus.illegal_o = r_main_pay[PAY_W-1];
`else
    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i (bus.instr_i),
        .imm_src (bus.imm_src),
        .imm_o   (w_imm)
    );

    assign w_in_pay = {bus.tag_i, w_imm};
`endif

    // r_in_ready mirrors !r_skid_valid as its own flop, so out_ready never reaches in_ready
    assign w_acc     = bus.in_valid && r_in_ready;
    assign w_main_ld = !r_main_valid || bus.out_ready;

    // Main/skid register update: skid has priority for refilling main to keep FIFO order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_pay   <= '0;
            r_skid_pay   <= '0;
        end else if (w_main_ld) begin
            if (r_skid_valid) begin
                r_main_pay   <= r_skid_pay;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_main_valid <= w_acc;
                if (w_acc) r_main_pay <= w_in_pay;
            end
        end else if (w_acc) begin
            r_skid_pay   <= w_in_pay;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.imm_o     = r_main_pay[XLEN-1:0];
    assign bus.tag_o     = r_main_pay[XLEN +: TAG_W];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: drives RV32 and RV64 instances in lockstep.
// Optional feature macro: IMM_GEN_ILLEGAL_EN (also checks illegal_o).
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int unsigned TW = 32;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   ins_w     = '0;
    logic [2:0]    src_w     = '0;
    logic [TW-1:0] tag_w     = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0]   imm;
        logic [TW-1:0] tag;
        logic          ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) if32();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) if64();

    assign if32.in_valid  = in_valid;
    assign if32.instr_i   = ins_w[31:7];
    assign if32.imm_src   = src_w;
    assign if32.tag_i     = tag_w;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.instr_i   = ins_w[31:7];
    assign if64.imm_src   = src_w;
    assign if64.tag_i     = tag_w;
    assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) u_dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference immediate, built arithmetically rather than by field concatenation
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
        logic [31:0] r;
        logic        sx;
        logic [12:0] b;
        logic [20:0] j;
        r  = '0;
        sx = 1'b1;
        b  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (src)
            3'd0: r = 32'($signed(ins) >>> 20);
            3'd1: r = ins & 32'hFFFF_F000;
            3'd2: r = (32'($signed(ins) >>> 25) << 5) | ((ins >> 7) & 32'h1F);
            3'd3: r = 32'($signed(b));
            3'd4: r = 32'($signed(j));
            3'd5: begin r = (ins >> 15) & 32'h1F; sx = 1'b0; end
            3'd6: begin r = (ins >> 20) & ((xlen == 64) ? 32'h3F : 32'h1F); sx = 1'b0; end
            default: r = '0;
        endcase
        ref_imm = (sx && r[31]) ? {32'hFFFF_FFFF, r} : {32'h0, r};
    endfunction

    function automatic logic ref_ill(input logic [31:0] ins, input logic [2:0] src, input int xlen);
        ref_ill = (src == 3'd7) || (src == 3'd6 && xlen == 32 && ins[25]);
    endfunction

    // RV32 scoreboard: compare head while valid, pop on drain, push on accept
    always @(negedge clk) begin
        if (rst) q32.delete();
        else begin
            if (q32.size() == 0) check("x32_unexpected_out", 64'(if32.out_valid), 64'd0);
            else if (if32.out_valid) begin
                check("x32_imm", 64'(if32.imm_o), {32'd0, q32[0].imm[31:0]});
                check("x32_tag", 64'(if32.tag_o), 64'(q32[0].tag));
`ifdef IMM_GEN_ILLEGAL_EN
                check("x32_ill", 64'(if32.illegal_o), 64'(q32[0].ill));
`endif
                if (out_ready) void'(q32.pop_front());
            end
            if (in_valid && if32.in_ready)
                q32.push_back('{imm: ref_imm(ins_w, src_w, 32), tag: tag_w, ill: ref_ill(ins_w, src_w, 32)});
        end
    end

    // RV64 scoreboard
    always @(negedge clk) begin
        if (rst) q64.delete();
        else begin
            if (q64.size() == 0) check("x64_unexpected_out", 64'(if64.out_valid), 64'd0);
            else if (if64.out_valid) begin
                check("x64_imm", if64.imm_o, q64[0].imm);
                check("x64_tag", 64'(if64.tag_o), 64'(q64[0].tag));
`ifdef IMM_GEN_ILLEGAL_EN
                check("x64_ill", 64'(if64.illegal_o), 64'(q64[0].ill));
`endif
                if (out_ready) void'(q64.pop_front());
            end
            if (in_valid && if64.in_ready)
                q64.push_back('{imm: ref_imm(ins_w, src_w, 64), tag: tag_w, ill: ref_ill(ins_w, src_w, 64)});
        end
    end

    // Present one instruction and hold it until accepted; returns just after the accepting edge
    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [TW-1:0] tg);
        int n;
        n        = 0;
        in_valid = 1'b1;
        ins_w    = ins;
        src_w    = src;
        tag_w    = tg;
        @(negedge clk);
        while (!if32.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Single transfer with known constant results on both widths
    task automatic directed(input string nm, input logic [31:0] ins, input logic [2:0] src,
                            input logic [TW-1:0] tg, input logic [63:0] e32, input logic [63:0] e64);
        send(ins, src, tg);
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_valid32"}, 64'(if32.out_valid), 64'd1);
        check({nm, "_imm32"},   64'(if32.imm_o), e32);
        check({nm, "_tag32"},   64'(if32.tag_o), 64'(tg));
        check({nm, "_imm64"},   if64.imm_o, e64);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid32", 64'(if32.out_valid), 64'd0);
        check("rst_imm32",   64'(if32.imm_o), 64'd0);
        check("rst_tag32",   64'(if32.tag_o), 64'd0);
        check("rst_ready32", 64'(if32.in_ready), 64'd1);
        check("rst_valid64", 64'(if64.out_valid), 64'd0);
        check("rst_imm64",   if64.imm_o, 64'd0);
        check("rst_ready64", 64'(if64.in_ready), 64'd1);
`ifdef IMM_GEN_ILLEGAL_EN
        check("rst_ill32", 64'(if32.illegal_o), 64'd0);
`endif
        @(posedge clk);
        #1 out_ready = 1'b1;

        directed("i_neg1", 32'hFFF0_0093, 3'd0, 32'hA5A5_0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        directed("b_neg4", 32'hFE00_0EE3, 3'd3, 32'hA5A5_0002, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
        directed("u_pos",  32'h1234_50B7, 3'd1, 32'hA5A5_0003, 64'h1234_5000, 64'h0000_0000_1234_5000);
        directed("u_neg",  32'h8000_0037, 3'd1, 32'hA5A5_0004, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
        directed("sh_63",  32'h03F0_9093, 3'd6, 32'hA5A5_0005, 64'h0000_001F, 64'h0000_0000_0000_003F);

        // Backpressure: second accept lands in skid, third is held off
        send(32'h0010_0013, 3'd0, 32'h101);
        out_ready = 1'b0;
        send(32'h0020_0013, 3'd0, 32'h102);
        ins_w = 32'h0030_0013;
        tag_w = 32'h103;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready32", 64'(if32.in_ready), 64'd0);
            check("bp_ready64", 64'(if64.in_ready), 64'd0);
            check("bp_hold32",  64'(if32.imm_o), 64'd1);
            check("bp_hold64",  if64.imm_o, 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        fork
            begin
                send(32'h0030_0013, 3'd0, 32'h103);
                send(32'h0040_0013, 3'd0, 32'h104);
                in_valid = 1'b0;
            end
            begin
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    check("bp_drain_valid", 64'(if32.out_valid), 64'd1);
                    check("bp_drain_imm32", 64'(if32.imm_o), 64'(k));
                    check("bp_drain_imm64", if64.imm_o, 64'(k));
                end
            end
        join
        @(posedge clk);
        #1;

        // Full rate: 16 random instructions, results on 16 consecutive cycles
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send($urandom, 3'($urandom_range(0, 7)), $urandom);
                in_valid = 1'b0;
            end
            begin
                w = 0;
                @(negedge clk);
                while (!if32.out_valid && w < 20) begin
                    w++;
                    @(negedge clk);
                end
                if (w >= 20) check("fr_start_timeout", 64'd1, 64'd0);
                for (int i = 0; i < 16; i++) begin
                    check("fr_valid32", 64'(if32.out_valid), 64'd1);
                    check("fr_valid64", 64'(if64.out_valid), 64'd1);
                    if (i < 15) @(negedge clk);
                end
            end
        join
        @(posedge clk);
        #1;

        // Reset with both entries full: nothing survives
        out_ready = 1'b0;
        send(32'h0050_0013, 3'd0, 32'h105);
        send(32'h0060_0013, 3'd0, 32'h106);
        in_valid = 1'b0;
        @(negedge clk);
        check("rm_full32", 64'(if32.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rm_valid32", 64'(if32.out_valid), 64'd0);
        check("rm_ready32", 64'(if32.in_ready), 64'd1);
        check("rm_valid64", 64'(if64.out_valid), 64'd0);
        check("rm_ready64", 64'(if64.in_ready), 64'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;

`ifdef IMM_GEN_ILLEGAL_EN
        send(32'h1234_5678, 3'd7, 32'h201);
        in_valid = 1'b0;
        @(negedge clk);
        check("ill_rsvd32", 64'(if32.illegal_o), 64'd1);
        check("ill_rsvd64", 64'(if64.illegal_o), 64'd1);
        check("ill_rsvd_imm32", 64'(if32.imm_o), 64'd0);
        @(posedge clk);
        #1;
        send(32'h0070_0013, 3'd0, 32'h202);
        in_valid = 1'b0;
        @(negedge clk);
        check("ill_clear32", 64'(if32.illegal_o), 64'd0);
        check("ill_clear_imm32", 64'(if32.imm_o), 64'd7);
        @(posedge clk);
        #1;
        send(32'h03F0_9093, 3'd6, 32'h203);
        in_valid = 1'b0;
        @(negedge clk);
        check("ill_sh32", 64'(if32.illegal_o), 64'd1);
        check("ill_sh64", 64'(if64.illegal_o), 64'd0);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q64_drained", 64'(q64.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
